mips_cpu_harvard: RTL and testbench
===================================

Name: mips_cpu_harvard

Overview:
- Single-cycle, non-pipelined MIPS-I subset CPU with a Harvard interface.
- Separate combinational instruction-fetch and data ports connect to external mips_cpu_iMemory (asynchronous read) and mips_cpu_dMemory (synchronous write on clk, combinational read).
- Runs from the reset vector until it jumps to address 0, then drops active.
- Exposes $v0 for end-of-program checking.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- active  output  1  high while CPU is executing; low once halted.
- register_v0  output  32  live value of GPR $2.
- clk_enable  input  1  when low, no architectural state changes (PC, GPRs, HI/LO, halt flag).
- instr_address  output  32  byte address of current instruction; equals PC.
- instr_readdata  input  32  instruction word, valid combinationally.
- data_address  output  32  byte address for load/store (rs + sign-extended imm).
- data_write  output  1  high during SW execution.
- data_read  output  1  high during LW execution.
- data_writedata  output  32  rt value during SW.
- data_readdata  input  32  load data, valid combinationally.

Behaviour:
- Reset (rst=1 at posedge): PC=RESET_VECTOR, next-PC=RESET_VECTOR+4, all GPRs=0, HI=LO=0, active=1, no pending branch. Reset takes precedence over clk_enable.
- Execution: one instruction per enabled cycle. Decode, register read, ALU and memory access are combinational from instr_readdata. GPR, HI/LO and PC updates occur at posedge when clk_enable=1.
- Branch delay slot: PC advances through a PC/next-PC pair. Taken branches and jumps load their target into next-PC, so the following instruction always executes.
- Halt: when PC becomes 32'h0 (after a jump to 0 and its delay slot), active goes low on that edge and stays low until rst. While halted, data_write=0, data_read=0 and state is frozen.
- $0 reads 0 and ignores writes. Register writes of rd/rt occur the same edge. Reads see pre-edge values.
- Supported instructions:
  - ADDU, ADDIU, SUBU, AND, ANDI, OR, ORI, XOR, XORI, NOR.
  - SLT, SLTI (signed compares); SLTU, SLTIU (unsigned).
  - SLL, SRL, SRA, SLLV, SRLV, SRAV (shift amount = low 5 bits).
  - LUI.
  - LW, SW.
  - BEQ, BNE, BGTZ, BLEZ, BLTZ, BGEZ, BLTZAL, BGEZAL.
  - J, JAL, JR, JALR.
  - MULT, MULTU (64-bit product to HI:LO), DIV, DIVU (LO=quotient, HI=remainder).
  - MFHI, MFLO, MTHI, MTLO.
- Immediates: ANDI/ORI/XORI zero-extend; all others sign-extend. SLTIU compares unsigned against the sign-extended immediate.
- Branch target = PC+4 + (sext(imm)<<2). Jump target = {PC+4[31:28], imm26, 2'b00}.
- Link instructions write PC+8 (JAL/BxxZAL to $31; JALR to rd). Link is written whether or not the branch is taken.
- DIV/DIVU by zero: HI and LO are left unchanged.
- Undefined opcodes and funct codes execute as NOP.
- data_read and data_write are mutually exclusive and asserted only for the LW/SW cycle. Addresses are assumed word-aligned; the low 2 bits are passed through unchanged.
- register_v0 is combinational from the register file.

Test Plan:
- Reset: rst high one cycle -> instr_address=BFC00000, active=1, register_v0=0 on the following cycle.
- Arithmetic and halt: ADDIU $2,$0,5; ADDIU $2,$2,-2; JR $0 (with $0 target); NOP -> active falls after the delay slot, register_v0=3.
- Memory: LUI $3,0x1000; ADDIU $4,$0,0x1234; SW $4,4($3); LW $2,4($3) -> data_write pulse at address 0x10000004 with data 0x1234, then register_v0=0x1234.
- Branch delay slot: BEQ $0,$0,+2; ADDIU $2,$0,7; ADDIU $2,$0,9 (skipped) -> register_v0=7. Delay-slot instruction executes, skipped instruction does not.
- JAL/JR: JAL to subroutine, subroutine does ADDIU $2,$31,0 -> register_v0 = call PC+8.
- Multiply/divide and clk_enable: MULT of 0x10000 by 0x10000 then MFHI $2 -> register_v0=1. With clk_enable held low for 5 cycles mid-program, PC and registers stay unchanged.

Source files
------------

// File: rtl/mips_cpu_harvard.sv
// rtl/mips_cpu_harvard.sv - single-cycle MIPS-I subset CPU with Harvard instruction/data ports
module mips_cpu_harvard #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI  = 6'h0F, OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03, FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR    = 6'h08, FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO  = 6'h12, FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2A, FN_SLTU  = 6'h2B;

    logic [31:0] pc_q, pc_d, npc_q, npc_d, hi_q, hi_d, lo_q, lo_d;
    logic        active_q, active_d;
    logic [31:0] gpr_q [32];

    logic        gpr_we, gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        branch_taken;
    logic [31:0] branch_tgt;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_zext, rs_val, rt_val;
    logic [31:0] pc_plus4, pc_plus8, br_target, j_target;
    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        exec;

    assign op       = instr_readdata[31:26];
    assign rs       = instr_readdata[25:21];
    assign rt       = instr_readdata[20:16];
    assign rd       = instr_readdata[15:11];
    assign shamt    = instr_readdata[10:6];
    assign funct    = instr_readdata[5:0];
    assign imm      = instr_readdata[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    assign rs_val   = gpr_q[rs];
    assign rt_val   = gpr_q[rt];

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_plus8  = pc_q + 32'd8;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};

    // Signed product via sign-extended 64-bit operands; the low 64 bits are exact.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'h0, rs_val} * {32'h0, rt_val};
    assign quo_s  = $signed(rs_val) / $signed(rt_val);
    assign rem_s  = $signed(rs_val) % $signed(rt_val);
    assign quo_u  = rs_val / rt_val;
    assign rem_u  = rs_val % rt_val;

    assign exec = active_q & clk_enable;

    always_comb begin
        gpr_we       = 1'b0;
        gpr_waddr    = rd;
        gpr_wdata    = 32'h0;
        hi_d         = hi_q;
        lo_d         = lo_q;
        branch_taken = 1'b0;
        branch_tgt   = br_target;
        case (op)
            OP_SPECIAL: begin
                gpr_we = 1'b1;
                case (funct)
                    FN_SLL:   gpr_wdata = rt_val << shamt;
                    FN_SRL:   gpr_wdata = rt_val >> shamt;
                    FN_SRA:   gpr_wdata = $signed(rt_val) >>> shamt;
                    FN_SLLV:  gpr_wdata = rt_val << rs_val[4:0];
                    FN_SRLV:  gpr_wdata = rt_val >> rs_val[4:0];
                    FN_SRAV:  gpr_wdata = $signed(rt_val) >>> rs_val[4:0];
                    FN_JR: begin
                        gpr_we       = 1'b0;
                        branch_taken = 1'b1;
                        branch_tgt   = rs_val;
                    end
                    FN_JALR: begin
                        branch_taken = 1'b1;
                        branch_tgt   = rs_val;
                        gpr_wdata    = pc_plus8;
                    end
                    FN_MFHI:  gpr_wdata = hi_q;
                    FN_MFLO:  gpr_wdata = lo_q;
                    FN_MTHI: begin
                        gpr_we = 1'b0;
                        hi_d   = rs_val;
                    end
                    FN_MTLO: begin
                        gpr_we = 1'b0;
                        lo_d   = rs_val;
                    end
                    FN_MULT: begin
                        gpr_we       = 1'b0;
                        {hi_d, lo_d} = prod_s;
                    end
                    FN_MULTU: begin
                        gpr_we       = 1'b0;
                        {hi_d, lo_d} = prod_u;
                    end
                    FN_DIV: begin
                        gpr_we = 1'b0;
                        if (rt_val != 32'h0) begin
                            lo_d = quo_s;
                            hi_d = rem_s;
                        end
                    end
                    FN_DIVU: begin
                        gpr_we = 1'b0;
                        if (rt_val != 32'h0) begin
                            lo_d = quo_u;
                            hi_d = rem_u;
                        end
                    end
                    FN_ADDU:  gpr_wdata = rs_val + rt_val;
                    FN_SUBU:  gpr_wdata = rs_val - rt_val;
                    FN_AND:   gpr_wdata = rs_val & rt_val;
                    FN_OR:    gpr_wdata = rs_val | rt_val;
                    FN_XOR:   gpr_wdata = rs_val ^ rt_val;
                    FN_NOR:   gpr_wdata = ~(rs_val | rt_val);
                    FN_SLT:   gpr_wdata = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLTU:  gpr_wdata = {31'h0, rs_val < rt_val};
                    default:  gpr_we = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                // rt encodes BLTZ/BGEZ in bit 0 and the link variant in bit 4.
                if (rt[3:1] == 3'b000) begin
                    branch_taken = rs_val[31] ^ rt[0];
                    gpr_we       = rt[4];
                    gpr_waddr    = 5'd31;
                    gpr_wdata    = pc_plus8;
                end
            end
            OP_J: begin
                branch_taken = 1'b1;
                branch_tgt   = j_target;
            end
            OP_JAL: begin
                branch_taken = 1'b1;
                branch_tgt   = j_target;
                gpr_we       = 1'b1;
                gpr_waddr    = 5'd31;
                gpr_wdata    = pc_plus8;
            end
            OP_BEQ:  branch_taken = (rs_val == rt_val);
            OP_BNE:  branch_taken = (rs_val != rt_val);
            OP_BLEZ: branch_taken = rs_val[31] | (rs_val == 32'h0);
            OP_BGTZ: branch_taken = ~rs_val[31] & (rs_val != 32'h0);
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                gpr_we    = 1'b1;
                gpr_waddr = rt;
                case (op)
                    OP_ADDIU: gpr_wdata = rs_val + imm_sext;
                    OP_SLTI:  gpr_wdata = {31'h0, $signed(rs_val) < $signed(imm_sext)};
                    OP_SLTIU: gpr_wdata = {31'h0, rs_val < imm_sext};
                    OP_ANDI:  gpr_wdata = rs_val & imm_zext;
                    OP_ORI:   gpr_wdata = rs_val | imm_zext;
                    OP_XORI:  gpr_wdata = rs_val ^ imm_zext;
                    OP_LUI:   gpr_wdata = {imm, 16'h0000};
                    default:  gpr_wdata = data_readdata;
                endcase
            end
            default: ;
        endcase
    end

    // The instruction after a branch always runs: the target only ever lands in npc.
    always_comb begin
        pc_d     = pc_q;
        npc_d    = npc_q;
        active_d = active_q;
        if (exec) begin
            pc_d     = npc_q;
            npc_d    = branch_taken ? branch_tgt : npc_q + 32'd4;
            active_d = (npc_q != 32'h0);
        end
    end

    assign gpr_wen = exec & gpr_we & (gpr_waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_VECTOR;
            npc_q    <= RESET_VECTOR + 32'd4;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            active_q <= 1'b1;
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= 32'h0;
            end
        end else begin
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            hi_q     <= exec ? hi_d : hi_q;
            lo_q     <= exec ? lo_d : lo_q;
            active_q <= active_d;
            if (gpr_wen) begin
                gpr_q[gpr_waddr] <= gpr_wdata;
            end
        end
    end

    assign active         = active_q;
    assign register_v0    = gpr_q[2];
    assign instr_address  = pc_q;
    assign data_address   = rs_val + imm_sext;
    assign data_writedata = rt_val;
    assign data_read      = active_q & (op == OP_LW);
    assign data_write     = exec & (op == OP_SW);

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// tb/tb_mips_cpu_harvard.sv - directed self-checking bench for mips_cpu_harvard
module tb_mips_cpu_harvard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b1;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_write, data_read;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];

    always #5 clk = ~clk;

    assign instr_readdata = (instr_address[31:8] == 24'hBFC000) ? imem[instr_address[7:2]] : 32'h0;
    assign data_readdata  = dmem[data_address[7:2]];

    always @(posedge clk) begin
        if (data_write) dmem[data_address[7:2]] <= data_writedata;
    end

    mips_cpu_harvard dut (
        .clk            (clk),
        .rst            (rst),
        .active         (active),
        .register_v0    (register_v0),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    localparam logic [31:0] NOP = 32'h0;
    localparam logic [31:0] RV  = 32'hBFC00000;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = NOP;
    endtask

    task automatic do_reset();
        clk_enable = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_pc", instr_address, RV);
        check("reset_active", {31'h0, active}, 32'h1);
        check("reset_v0", register_v0, 32'h0);
    endtask

    task automatic run_until_halt(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (active === 1'b1 && n < max_cycles) begin
            step(1);
            n++;
        end
        check(tag, {31'h0, active}, 32'h0);
    endtask

    initial begin
        // Arithmetic then JR $0 with a delay slot, halt, then frozen state
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd5);
        imem[1] = enc_i(6'h09, 5'd2, 5'd2, 16'hFFFE);
        imem[2] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[3] = NOP;
        do_reset();
        step(3);
        check("arith_active_in_slot", {31'h0, active}, 32'h1);
        step(1);
        check("arith_halt_edge", {31'h0, active}, 32'h0);
        check("arith_v0", register_v0, 32'h3);
        check("arith_pc0", instr_address, 32'h0);
        step(3);
        check("halt_frozen_pc", instr_address, 32'h0);
        check("halt_frozen_active", {31'h0, active}, 32'h0);
        check("halt_no_write", {31'h0, data_write}, 32'h0);

        // Store then load through the data port
        clear_imem();
        imem[0] = enc_i(6'h0F, 5'd0, 5'd3, 16'h1000);
        imem[1] = enc_i(6'h09, 5'd0, 5'd4, 16'h1234);
        imem[2] = enc_i(6'h2B, 5'd3, 5'd4, 16'd4);
        imem[3] = enc_i(6'h23, 5'd3, 5'd2, 16'd4);
        imem[4] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[5] = NOP;
        do_reset();
        step(2);
        check("sw_write", {31'h0, data_write}, 32'h1);
        check("sw_read", {31'h0, data_read}, 32'h0);
        check("sw_addr", data_address, 32'h10000004);
        check("sw_data", data_writedata, 32'h00001234);
        step(1);
        check("lw_read", {31'h0, data_read}, 32'h1);
        check("lw_write", {31'h0, data_write}, 32'h0);
        check("lw_addr", data_address, 32'h10000004);
        step(1);
        check("lw_v0", register_v0, 32'h00001234);
        run_until_halt("mem_halt", 10);

        // Taken BEQ: delay slot runs, the skipped instruction does not
        clear_imem();
        imem[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        imem[1] = enc_i(6'h09, 5'd0, 5'd2, 16'd7);
        imem[2] = enc_i(6'h09, 5'd0, 5'd2, 16'd9);
        imem[3] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[4] = NOP;
        do_reset();
        step(2);
        check("beq_target_pc", instr_address, 32'hBFC0000C);
        check("beq_slot_v0", register_v0, 32'h7);
        run_until_halt("beq_halt", 10);
        check("beq_final_v0", register_v0, 32'h7);

        // JAL to a subroutine that copies $31 into $2, returns via JR $31
        clear_imem();
        imem[0]  = enc_j(6'h03, 32'hBFC00020);
        imem[1]  = NOP;
        imem[2]  = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[3]  = NOP;
        imem[8]  = enc_i(6'h09, 5'd31, 5'd2, 16'd0);
        imem[9]  = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[10] = NOP;
        do_reset();
        step(2);
        check("jal_target_pc", instr_address, 32'hBFC00020);
        step(3);
        check("jr_return_pc", instr_address, 32'hBFC00008);
        check("jal_link_v0", register_v0, 32'hBFC00008);
        run_until_halt("jal_halt", 10);

        // MULT then MFHI, with clk_enable dropped for five cycles in between
        clear_imem();
        imem[0] = enc_i(6'h0F, 5'd0, 5'd5, 16'h0001);
        imem[1] = enc_r(5'd5, 5'd5, 5'd0, 5'd0, 6'h18);
        imem[2] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h10);
        imem[3] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[4] = NOP;
        do_reset();
        step(2);
        clk_enable = 1'b0;
        step(5);
        check("stall_pc", instr_address, 32'hBFC00008);
        check("stall_v0", register_v0, 32'h0);
        check("stall_no_write", {31'h0, data_write}, 32'h0);
        clk_enable = 1'b1;
        step(1);
        check("mfhi_v0", register_v0, 32'h1);
        run_until_halt("mult_halt", 10);

        // Signed DIV, then DIV by zero must leave HI/LO intact
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd8, 16'd100);
        imem[1] = enc_i(6'h09, 5'd0, 5'd9, 16'hFFF9);
        imem[2] = enc_r(5'd8, 5'd9, 5'd0, 5'd0, 6'h1A);
        imem[3] = enc_r(5'd8, 5'd0, 5'd0, 5'd0, 6'h1A);
        imem[4] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h12);
        imem[5] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h10);
        imem[6] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[7] = NOP;
        do_reset();
        step(5);
        check("div_lo_v0", register_v0, 32'hFFFFFFF2);
        step(1);
        check("div_hi_v0", register_v0, 32'h00000002);
        run_until_halt("div_halt", 10);

        // Shifts, compares, zero-extended ORI, $0 writes, SLLV, BGEZAL not-taken link
        clear_imem();
        imem[0]  = enc_i(6'h09, 5'd0, 5'd3, 16'hFFF0);
        imem[1]  = enc_r(5'd0, 5'd3, 5'd2, 5'd2, 6'h03);
        imem[2]  = enc_r(5'd0, 5'd3, 5'd2, 5'd28, 6'h02);
        imem[3]  = enc_r(5'd0, 5'd3, 5'd2, 5'd0, 6'h2B);
        imem[4]  = enc_r(5'd0, 5'd3, 5'd2, 5'd0, 6'h2A);
        imem[5]  = enc_i(6'h0B, 5'd3, 5'd2, 16'd5);
        imem[6]  = enc_i(6'h0D, 5'd0, 5'd2, 16'hFFFF);
        imem[7]  = enc_i(6'h09, 5'd0, 5'd0, 16'd5);
        imem[8]  = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h21);
        imem[9]  = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h27);
        imem[10] = enc_r(5'd3, 5'd2, 5'd2, 5'd0, 6'h04);
        imem[11] = enc_i(6'h01, 5'd3, 5'h11, 16'd5);
        imem[12] = enc_i(6'h09, 5'd31, 5'd2, 16'd0);
        imem[13] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[14] = NOP;
        do_reset();
        step(2);  check("sra_v0", register_v0, 32'hFFFFFFFC);
        step(1);  check("srl_v0", register_v0, 32'h0000000F);
        step(1);  check("sltu_v0", register_v0, 32'h00000001);
        step(1);  check("slt_v0", register_v0, 32'h00000000);
        step(1);  check("sltiu_v0", register_v0, 32'h00000000);
        step(1);  check("ori_zext_v0", register_v0, 32'h0000FFFF);
        step(2);  check("zero_reg_v0", register_v0, 32'h00000000);
        step(1);  check("nor_v0", register_v0, 32'hFFFFFFFF);
        step(1);  check("sllv_v0", register_v0, 32'hFFFF0000);
        step(1);  check("bgezal_fallthru_pc", instr_address, 32'hBFC00030);
        step(1);  check("bgezal_link_v0", register_v0, 32'hBFC00034);
        run_until_halt("misc_halt", 10);

        // Reset clears a non-zero $v0 and restarts from the reset vector
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
